// File: rtl/mem_access_arbiter.sv
// -----------------------------------------------------------------------------
// mem_access_arbiter
//
// Shares one memory port (MAR/MBR with the MFA/MFC handshake) between the
// instruction-fetch requester (F) and the data load/store requester (D).
// A request is sampled only in IDLE. A tie goes to whichever requester did
// not win last time. The winner's address and controls are latched and
// presented for one SETUP cycle, then MFA is raised in WAIT until MFC returns
// or the timeout expires. DONE then pulses the winner's ack for one cycle.
//
// Ports
//   Clk, Reset        clock, synchronous active-high reset
//   f_req, f_addr     fetch request (always a word read)
//   f_ack             one-cycle fetch completion pulse
//   d_req, d_addr     data request and address
//   d_wdata           store data
//   d_rw, d_wb        1=read/0=write, 1=word/0=byte
//   d_ack             one-cycle data completion pulse
//   err               qualifies the ack: completion was a timeout
//   rdata             last read result, held until the next read completes
//   busy              high whenever the FSM is not in IDLE
//   MAR_OUT, MBR_OUT  memory address and write data
//   MFA               memory function active
//   READ_WRITE        1=read, 0=write
//   WORD_BYTE         1=word, 0=byte
//   MFC, MEM_DATA     memory function complete and read data
//
// Every output is decoded from registers only, so nothing combinational
// passes from an input straight through to an output.
// -----------------------------------------------------------------------------
module mem_access_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              d_rw,
    input  logic              d_wb,
    output logic              d_ack,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] MAR_OUT,
    output logic [DATA_W-1:0] MBR_OUT,
    output logic              MFA,
    output logic              READ_WRITE,
    output logic              WORD_BYTE,
    input  logic              MFC,
    input  logic [DATA_W-1:0] MEM_DATA
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SETUP = 2'b01,
        ST_WAIT  = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    typedef enum logic {
        GNT_F = 1'b0,
        GNT_D = 1'b1
    } grant_t;

    // Last WAIT count before the timeout fires; the counter is 8 bits wide
    // because TIMEOUT is limited to 255.
    localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

    state_t              r_state;
    grant_t              r_last_grant;   // also identifies the current winner
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_rw;
    logic                r_wb;
    logic [7:0]          r_wait_cnt;
    logic                r_err_flag;
    logic [DATA_W-1:0]   r_rdata;

    state_t              w_next_state;
    logic                w_any_req;
    grant_t              w_grant;
    logic                w_timeout_hit;
    logic [DATA_W-1:0]   w_read_value;

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values of its sources, independent of block ordering.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------------------------------------------------------------
    // Arbitration and next-state decode
    // ---------------------------------------------------------------------
    // NOTE: every signal written here is given a default first, so no path
    // through the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_next_state  = r_state;
        w_any_req     = f_req | d_req;
        w_grant       = GNT_F;
        w_timeout_hit = (r_wait_cnt == LP_CNT_LAST);
        w_read_value  = MEM_DATA;

        // D wins when it is alone, or on a tie when F had the last grant.
        if (d_req && (!f_req || (r_last_grant == GNT_F))) begin
            w_grant = GNT_D;
        end

        if (!r_wb) begin
            w_read_value = {{(DATA_W-8){1'b0}}, MEM_DATA[7:0]};
        end

        case (r_state)
            ST_IDLE:  if (w_any_req) w_next_state = ST_SETUP;
            // Hold off MFA until the previous handshake's MFC has released.
            ST_SETUP: if (!MFC)      w_next_state = ST_WAIT;
            ST_WAIT:  if (MFC || w_timeout_hit) w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Request latch, wait counter, completion status and read data
    // ---------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_last_grant <= GNT_F;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rw         <= 1'b1;
            r_wb         <= 1'b1;
            r_wait_cnt   <= '0;
            r_err_flag   <= 1'b0;
            r_rdata      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_last_grant <= w_grant;
                        if (w_grant == GNT_D) begin
                            r_addr  <= d_addr;
                            r_wdata <= d_wdata;
                            r_rw    <= d_rw;
                            r_wb    <= d_wb;
                        end else begin
                            // Fetch is always a word read; store data is left as is.
                            r_addr  <= f_addr;
                            r_rw    <= 1'b1;
                            r_wb    <= 1'b1;
                        end
                    end
                end
                ST_SETUP: begin
                    r_wait_cnt <= '0;
                end
                ST_WAIT: begin
                    if (MFC) begin
                        r_err_flag <= 1'b0;
                        if (r_rw) begin
                            r_rdata <= w_read_value;
                        end
                    end else if (w_timeout_hit) begin
                        r_err_flag <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Moore outputs
    // ---------------------------------------------------------------------
    assign MFA        = (r_state == ST_WAIT);
    assign busy       = (r_state != ST_IDLE);
    assign f_ack      = (r_state == ST_DONE) && (r_last_grant == GNT_F);
    assign d_ack      = (r_state == ST_DONE) && (r_last_grant == GNT_D);
    assign err        = (r_state == ST_DONE) && r_err_flag;
    assign rdata      = r_rdata;
    assign MAR_OUT    = r_addr;
    assign MBR_OUT    = r_wdata;
    assign READ_WRITE = r_rw;
    assign WORD_BYTE  = r_wb;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_access_arbiter
//
// Directed bench for mem_access_arbiter. Stimulus pushes the expected ack
// (which requester, err, rdata) into a scoreboard queue; an independent
// monitor pops and compares whenever f_ack or d_ack is seen. A small memory
// model answers MFA with MFC on the first WAIT cycle when enabled.
// -----------------------------------------------------------------------------
module tb_mem_access_arbiter;

    localparam int          ADDR_W  = 32;
    localparam int          DATA_W  = 32;
    localparam int          TIMEOUT = 15;
    localparam logic [31:0] KEY     = 32'hA5A5_0000;

    typedef struct {
        logic        is_d;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic              Clk      = 1'b0;
    logic              Reset    = 1'b1;
    logic              f_req    = 1'b0;
    logic [ADDR_W-1:0] f_addr   = '0;
    logic              f_ack;
    logic              d_req    = 1'b0;
    logic [ADDR_W-1:0] d_addr   = '0;
    logic [DATA_W-1:0] d_wdata  = '0;
    logic              d_rw     = 1'b1;
    logic              d_wb     = 1'b1;
    logic              d_ack;
    logic              err;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic [ADDR_W-1:0] MAR_OUT;
    logic [DATA_W-1:0] MBR_OUT;
    logic              MFA;
    logic              READ_WRITE;
    logic              WORD_BYTE;
    logic              MFC      = 1'b0;
    logic [DATA_W-1:0] MEM_DATA = '0;

    // Memory model controls
    logic        mfc_en     = 1'b1;
    logic        mem_fixed  = 1'b1;
    logic [31:0] fixed_data = '0;

    int          n_checks  = 0;
    int          n_pass    = 0;
    int          ack_count = 0;
    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] model_rdata = '0;

    always #5 Clk = ~Clk;

    mem_access_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_ack     (f_ack),
        .d_req     (d_req),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rw      (d_rw),
        .d_wb      (d_wb),
        .d_ack     (d_ack),
        .err       (err),
        .rdata     (rdata),
        .busy      (busy),
        .MAR_OUT   (MAR_OUT),
        .MBR_OUT   (MBR_OUT),
        .MFA       (MFA),
        .READ_WRITE(READ_WRITE),
        .WORD_BYTE (WORD_BYTE),
        .MFC       (MFC),
        .MEM_DATA  (MEM_DATA)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic expect_ack(input logic is_d, input logic e, input logic [31:0] rd);
        exp_t x;
        x.is_d  = is_d;
        x.err   = e;
        x.rdata = rd;
        sb_q.push_back(x);
    endtask

    // Waits (on falling edges) until an ack is visible, with a cycle bound.
    task automatic wait_ack(output int cycles);
        cycles = 0;
        do begin
            @(negedge Clk);
            cycles++;
        end while (!(f_ack || d_ack) && cycles < 60);
        check("ack_within_bound", 32'(f_ack | d_ack), 32'd1);
    endtask

    // Memory model: answers MFA on the first WAIT cycle when enabled.
    always @(posedge Clk) begin
        #1;
        MFC      = mfc_en && MFA;
        MEM_DATA = mem_fixed ? fixed_data : (MAR_OUT ^ KEY);
    end

    // Scoreboard monitor
    always @(negedge Clk) begin
        if (f_ack || d_ack) begin
            ack_count++;
            check("ack_exclusive", 32'(f_ack & d_ack), 32'd0);
            check("ack_expected", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                check("ack_is_d",  32'(d_ack), 32'(mon_e.is_d));
                check("ack_err",   32'(err),   32'(mon_e.err));
                check("ack_rdata", rdata,      mon_e.rdata);
            end
        end else begin
            check("err_without_ack", 32'(err), 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int mfa_cycles;
        int saved_acks;

        // ---------------- reset state ----------------
        repeat (2) @(posedge Clk);
        #1;
        check("rst_mfa",   32'(MFA),        32'd0);
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_rw",    32'(READ_WRITE), 32'd1);
        check("rst_wb",    32'(WORD_BYTE),  32'd1);
        check("rst_mar",   MAR_OUT,         32'd0);
        check("rst_mbr",   MBR_OUT,         32'd0);
        check("rst_rdata", rdata,           32'd0);
        check("rst_acks",  32'({f_ack, d_ack, err}), 32'd0);
        Reset = 1'b0;

        // ---------------- fetch word read, latency ----------------
        @(posedge Clk); #1;
        fixed_data  = 32'hDEADBEEF;
        mem_fixed   = 1'b1;
        mfc_en      = 1'b1;
        f_addr      = 32'h100;
        f_req       = 1'b1;
        model_rdata = 32'hDEADBEEF;
        expect_ack(1'b0, 1'b0, model_rdata);
        @(posedge Clk); #1;                  // edge 0: grant
        f_req = 1'b0;
        check("t1_setup_busy", 32'(busy), 32'd1);
        check("t1_setup_mfa",  32'(MFA),  32'd0);
        @(posedge Clk); #1;                  // edge 1: WAIT
        check("t1_wait_mfa", 32'(MFA),        32'd1);
        check("t1_mar",      MAR_OUT,         32'h100);
        check("t1_rw",       32'(READ_WRITE), 32'd1);
        check("t1_wb",       32'(WORD_BYTE),  32'd1);
        @(posedge Clk); #1;                  // edge 2: DONE
        check("t1_f_ack_latency", 32'(f_ack), 32'd1);
        check("t1_d_ack_low",     32'(d_ack), 32'd0);
        @(posedge Clk); #1;
        check("t1_ack_drop", 32'(f_ack), 32'd0);
        check("t1_idle",     32'(busy),  32'd0);

        // ---------------- data word write ----------------
        d_req   = 1'b1;
        d_rw    = 1'b0;
        d_wb    = 1'b1;
        d_addr  = 32'h20;
        d_wdata = 32'h12345678;
        expect_ack(1'b1, 1'b0, model_rdata);
        @(posedge Clk); #1;
        d_req = 1'b0;
        @(posedge Clk); #1;
        check("t2_mbr", MBR_OUT,         32'h12345678);
        check("t2_mar", MAR_OUT,         32'h20);
        check("t2_rw",  32'(READ_WRITE), 32'd0);
        check("t2_mfa", 32'(MFA),        32'd1);
        wait_ack(n);
        @(negedge Clk);
        check("t2_single_pulse", 32'(d_ack), 32'd0);

        // ---------------- data byte read ----------------
        @(posedge Clk); #1;
        fixed_data  = 32'hAABBCCF0;
        d_req       = 1'b1;
        d_rw        = 1'b1;
        d_wb        = 1'b0;
        d_addr      = 32'h24;
        model_rdata = 32'h000000F0;
        expect_ack(1'b1, 1'b0, model_rdata);
        @(posedge Clk); #1;
        d_req = 1'b0;
        @(posedge Clk); #1;
        check("t3_wb",  32'(WORD_BYTE),  32'd0);
        check("t3_rw",  32'(READ_WRITE), 32'd1);
        wait_ack(n);

        // ---------------- round-robin with both requests held ----------------
        @(posedge Clk); #1;
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset     = 1'b0;
        mem_fixed = 1'b0;
        f_addr    = 32'h400;
        d_addr    = 32'h800;
        d_rw      = 1'b1;
        d_wb      = 1'b1;
        expect_ack(1'b1, 1'b0, 32'h800 ^ KEY);
        expect_ack(1'b0, 1'b0, 32'h400 ^ KEY);
        expect_ack(1'b1, 1'b0, 32'h800 ^ KEY);
        expect_ack(1'b0, 1'b0, 32'h400 ^ KEY);
        f_req = 1'b1;
        d_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_ack(n);
            if (i > 0) check("rr_interval", 32'(n), 32'd4);
        end
        f_req       = 1'b0;
        d_req       = 1'b0;
        model_rdata = 32'h400 ^ KEY;

        // ---------------- timeout ----------------
        @(posedge Clk); #1;
        mfc_en = 1'b0;
        d_req  = 1'b1;
        d_rw   = 1'b1;
        d_wb   = 1'b1;
        d_addr = 32'h30;
        expect_ack(1'b1, 1'b1, model_rdata);
        @(posedge Clk); #1;
        d_req = 1'b0;
        mfa_cycles = 0;
        for (int i = 0; i < 60 && !(f_ack || d_ack); i++) begin
            @(negedge Clk);
            if (MFA) mfa_cycles++;
        end
        check("to_mfa_cycles", 32'(mfa_cycles), 32'(TIMEOUT));
        check("to_d_ack",      32'(d_ack),      32'd1);
        @(negedge Clk);
        check("to_busy_after", 32'(busy), 32'd0);

        // ---------------- reset during WAIT ----------------
        @(posedge Clk); #1;
        f_addr = 32'h500;
        f_req  = 1'b1;
        @(posedge Clk); #1;
        f_req = 1'b0;
        @(posedge Clk); #1;
        check("t6_in_wait", 32'(MFA), 32'd1);
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b1;
        @(posedge Clk); #1;
        check("t6_rst_mfa",  32'(MFA),  32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        Reset      = 1'b0;
        mfc_en     = 1'b1;
        saved_acks = ack_count;
        repeat (10) @(posedge Clk);
        #1;
        check("t6_no_ack", 32'(ack_count), 32'(saved_acks));

        // Tie after reset goes to D.
        mem_fixed = 1'b0;
        d_addr    = 32'h800;
        d_rw      = 1'b1;
        d_wb      = 1'b1;
        expect_ack(1'b1, 1'b0, 32'h800 ^ KEY);
        f_req = 1'b1;
        d_req = 1'b1;
        @(posedge Clk); #1;
        f_req = 1'b0;
        d_req = 1'b0;
        wait_ack(n);

        repeat (3) @(posedge Clk);
        #1;
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
